// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences a 1-cycle-latency instruction ROM and
// presents pc/instr/valid to decode, with stall hold and branch-redirect squash.
module fetch_sequencer #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     RESET_PC  = '0,
  parameter logic [31:0]         INSTR_NOP = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            misalign_err,
  output logic [31:0]     fetch_count,
  output logic [31:0]     squash_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   fetch_pc, fetch_pc_n;
  logic [XLEN-1:0]   req_pc, req_pc_n;
  logic              req_pending, req_pending_n;
  logic              misalign_n;
  logic [CNT_W-1:0]  fetch_count_n, squash_count_n;
  logic [XLEN-1:0]   redirect_addr;
  logic              accept;

  // Decode-facing triple; redirect kills the in-flight (wrong-path) word
  assign if_valid      = ~rst & req_pending & ~redirect;
  assign if_pc         = rst ? RESET_PC : req_pc;
  assign if_instr      = if_valid ? imem_rdata : INSTR_NOP;
  assign accept        = if_valid & ~stall;
  assign redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};

  // Next-state and ROM request; priority rst > redirect > stall
  always_comb begin
    state_n        = state;
    fetch_pc_n     = fetch_pc;
    req_pc_n       = req_pc;
    req_pending_n  = req_pending;
    misalign_n     = misalign_err;
    fetch_count_n  = fetch_count + CNT_W'(accept);
    squash_count_n = squash_count;
    imem_en        = 1'b0;
    imem_addr      = fetch_pc;

    if (rst) begin
      imem_en   = 1'b0;
      imem_addr = RESET_PC;
    end else if (redirect) begin
      imem_en       = 1'b1;
      imem_addr     = redirect_addr;
      fetch_pc_n    = redirect_addr + XLEN'(4);
      req_pc_n      = redirect_addr;
      req_pending_n = 1'b1;
      state_n       = RUN;
      if (req_pending)
        squash_count_n = squash_count + CNT_W'(1);
      if (redirect_pc[1:0] != 2'b00)
        misalign_n = 1'b1;
    end else if (stall && req_pending && (state != BOOT)) begin
      // ROM keeps its output while en=0, so if_instr stays stable
      imem_en = 1'b0;
      state_n = STALL;
    end else begin
      imem_en       = 1'b1;
      imem_addr     = fetch_pc;
      fetch_pc_n    = fetch_pc + XLEN'(4);
      req_pc_n      = fetch_pc;
      req_pending_n = 1'b1;
      state_n       = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      req_pc       <= RESET_PC;
      req_pending  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      state        <= state_n;
      fetch_pc     <= fetch_pc_n;
      req_pc       <= req_pc_n;
      req_pending  <= req_pending_n;
      misalign_err <= misalign_n;
      fetch_count  <= fetch_count_n;
      squash_count <= squash_count_n;
    end
  end

endmodule
